// File: rtl/frame_dma_pkg.sv
// rtl/frame_dma_pkg.sv - shared constants, types and helpers for the frame DMA writer
package frame_dma_pkg;

    localparam logic [1:0] TAG_MIDDLE = 2'b00;
    localparam logic [1:0] TAG_LAST   = 2'b01;
    localparam logic [1:0] TAG_FIRST  = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [47:0] DEF_DST_MAC = 48'hADAD_ADAD_ADAD;
    localparam logic [47:0] DEF_SRC_MAC = 48'hACAC_ACAC_ACAC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } wr_state_t;

    // Header occupies the top 96 bits of the first beat: destination MAC then source MAC.
    function automatic logic hdr_match(input logic [95:0] hdr,
                                       input logic [47:0] dst,
                                       input logic [47:0] src);
        return (hdr[95:48] == dst) && (hdr[47:0] == src);
    endfunction

endpackage

// File: rtl/frame_dma_writer_if.sv
// rtl/frame_dma_writer_if.sv - AXI4 write-channel bundle between the frame writer and DDR
interface frame_dma_writer_if #(
    parameter int ADDR_W = 32,
    parameter int AXI_DW = 64
);
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awlock;
    logic                awvalid;
    logic                awready;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/frame_dma_fifo.sv
// rtl/frame_dma_fifo.sv - synchronous show-ahead FIFO; head is valid whenever not empty
module frame_dma_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 512,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/frame_dma_writer.sv
// rtl/frame_dma_writer.sv - MAC-filtered packet ingress feeding ping-pong DDR frame writes
module frame_dma_writer
    import frame_dma_pkg::*;
#(
    parameter int              IN_W        = 512,
    parameter int              AXI_DW      = 64,
    parameter int              ADDR_W      = 32,
    parameter int              FIFO_DEPTH  = 32,
    parameter int              FRAME_BYTES = 614400,
    parameter logic [ADDR_W-1:0] BUF0_BASE = 32'h2BC0_0000,
    parameter logic [ADDR_W-1:0] BUF1_BASE = 32'h2BE0_0000,
    parameter logic [47:0]     DST_MAC     = DEF_DST_MAC,
    parameter logic [47:0]     SRC_MAC     = DEF_SRC_MAC,
    parameter int              ALF_MARGIN  = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              start_buf,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              done_buf,
    output logic              done_err,
    input  logic [IN_W+1:0]   pktin_data,
    input  logic              pktin_valid,
    output logic              pkt_alf,
    output logic [15:0]       drop_cnt,
    frame_dma_writer_if.master m_axi
);

    localparam int NSLICE      = IN_W / AXI_DW;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_BEATS = FRAME_BYTES / (IN_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(IN_W / 8);

    logic [1:0]       in_tag;
    logic [IN_W-1:0]  in_beat;
    logic             in_pkt;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      free_entries;
    logic             push_blocked;

    assign in_tag  = pktin_data[IN_W+1:IN_W];
    assign in_beat = pktin_data[IN_W-1:0];

    assign fifo_push    = pktin_valid && in_pkt && !in_tag[1];
    assign push_blocked = fifo_full && !fifo_pop;

    assign free_entries = 32'(FIFO_DEPTH) - 32'(fifo_count);
    assign pkt_alf      = (free_entries <= 32'(ALF_MARGIN));

    frame_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IN_W)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (in_beat),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // in_pkt tracks whether the current packet's payload is still wanted; a
    // blocked push clears it so the remainder of that packet is ignored.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            in_pkt   <= 1'b0;
            drop_cnt <= '0;
        end else if (pktin_valid) begin
            if (in_tag[1]) begin
                in_pkt <= (in_tag == TAG_FIRST) && hdr_match(in_beat[IN_W-1 -: 96], DST_MAC, SRC_MAC);
            end else if (in_pkt) begin
                if (push_blocked) begin
                    in_pkt <= 1'b0;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end else if (in_tag == TAG_LAST) begin
                    in_pkt <= 1'b0;
                end
            end
        end
    end

    wr_state_t         state;
    logic              awvalid_r;
    logic              wvalid_r;
    logic              wlast_r;
    logic              bready_r;
    logic              buf_sel;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       beat_cnt;
    logic [7:0]        w_cnt;
    logic [IN_W-1:0]   wbuf;
    logic              bresp_bad;

    assign bresp_bad = (m_axi.bresp != AXI_RESP_OKAY);
    assign fifo_pop  = (state == ST_W) && wvalid_r && wlast_r && m_axi.wready;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = addr;
    assign m_axi.awlen   = 8'(NSLICE - 1);
    assign m_axi.awsize  = 3'($clog2(AXI_DW / 8));
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awcache = AXI_CACHE_BUF;
    assign m_axi.awprot  = '0;
    assign m_axi.awqos   = '0;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awvalid = awvalid_r;
    assign m_axi.wdata   = wbuf[AXI_DW-1:0];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast_r;
    assign m_axi.wvalid  = wvalid_r;
    assign m_axi.bready  = bready_r;

    // wbuf snapshots the FIFO head at the address handshake and shifts right,
    // so slices leave LSB-first and stay stable while WREADY is low.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            start_ready <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            wlast_r     <= 1'b0;
            bready_r    <= 1'b0;
            done_valid  <= 1'b0;
            done_buf    <= 1'b0;
            done_err    <= 1'b0;
            buf_sel     <= 1'b0;
            err         <= 1'b0;
            addr        <= '0;
            beat_cnt    <= '0;
            w_cnt       <= '0;
            wbuf        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        start_ready <= 1'b0;
                        buf_sel     <= start_buf;
                        addr        <= start_buf ? BUF1_BASE : BUF0_BASE;
                        beat_cnt    <= '0;
                        err         <= 1'b0;
                        awvalid_r   <= !fifo_empty;
                        state       <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (!awvalid_r) begin
                        awvalid_r <= !fifo_empty;
                    end else if (m_axi.awready) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b1;
                        wlast_r   <= (NSLICE == 1);
                        wbuf      <= fifo_head;
                        w_cnt     <= '0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi.wready) begin
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                            state    <= ST_B;
                        end else begin
                            wbuf    <= wbuf >> AXI_DW;
                            w_cnt   <= w_cnt + 8'd1;
                            wlast_r <= (32'(w_cnt) + 32'd2 == 32'(NSLICE));
                        end
                    end
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        bready_r <= 1'b0;
                        err      <= err | bresp_bad;
                        addr     <= addr + ADDR_STEP;
                        beat_cnt <= beat_cnt + 32'd1;
                        if (beat_cnt + 32'd1 == 32'(FRAME_BEATS)) begin
                            done_valid <= 1'b1;
                            done_buf   <= buf_sel;
                            done_err   <= err | bresp_bad;
                            state      <= ST_DONE;
                        end else begin
                            awvalid_r <= !fifo_empty;
                            state     <= ST_AW;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        done_buf    <= 1'b0;
                        done_err    <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_dma_writer.sv
// tb/tb_frame_dma_writer.sv - randomized self-checking bench for frame_dma_writer
module tb_frame_dma_writer;

    localparam int IN_W        = 512;
    localparam int AXI_DW      = 64;
    localparam int ADDR_W      = 32;
    localparam int DEPTH       = 4;
    localparam int FRAME_BYTES = 256;
    localparam int ALF_MARGIN  = 1;
    localparam int NSLICE      = IN_W / AXI_DW;
    localparam int BEAT_BYTES  = IN_W / 8;
    localparam int FRAME_BEATS = FRAME_BYTES / BEAT_BYTES;
    localparam logic [31:0] BUF0 = 32'h2BC0_0000;
    localparam logic [31:0] BUF1 = 32'h2BE0_0000;
    localparam logic [47:0] DST  = 48'hADAD_ADAD_ADAD;
    localparam logic [47:0] SRC  = 48'hACAC_ACAC_ACAC;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic            start_buf = 1'b0;
    logic            done_valid;
    logic            done_ready = 1'b0;
    logic            done_buf;
    logic            done_err;
    logic [IN_W+1:0] pktin_data = '0;
    logic            pktin_valid = 1'b0;
    logic            pkt_alf;
    logic [15:0]     drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [IN_W-1:0] model_q[$];
    int model_drop = 0;

    frame_dma_writer_if #(.ADDR_W(ADDR_W), .AXI_DW(AXI_DW)) axi ();

    frame_dma_writer #(
        .IN_W        (IN_W),
        .AXI_DW      (AXI_DW),
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (DEPTH),
        .FRAME_BYTES (FRAME_BYTES),
        .ALF_MARGIN  (ALF_MARGIN)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_buf   (start_buf),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .done_buf    (done_buf),
        .done_err    (done_err),
        .pktin_data  (pktin_data),
        .pktin_valid (pktin_valid),
        .pkt_alf     (pkt_alf),
        .drop_cnt    (drop_cnt),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] b;
        for (int i = 0; i < IN_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic exp_alf();
        return (DEPTH - model_q.size()) <= ALF_MARGIN;
    endfunction

    // kind: 0 = matching header, 1 = wrong destination MAC, 2 = wrong source MAC
    task automatic send_packet(input int kind, input int n);
        logic [IN_W-1:0] hdr;
        logic [IN_W-1:0] beat;
        logic [1:0]      tag;
        bit              accepting;
        hdr = rand_beat();
        hdr[IN_W-1 -: 48]  = (kind == 1) ? (DST ^ 48'h0000_0100_0000) : DST;
        hdr[IN_W-49 -: 48] = (kind == 2) ? (SRC ^ 48'h8000_0000_0000) : SRC;
        tag = (n == 0) ? 2'b11 : 2'b10;
        pktin_valid = 1'b1;
        pktin_data  = {tag, hdr};
        accepting   = (kind == 0) && (n > 0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            beat = rand_beat();
            tag  = (i == n - 1) ? 2'b01 : 2'b00;
            pktin_data = {tag, beat};
            if (accepting) begin
                if (model_q.size() < DEPTH) begin
                    model_q.push_back(beat);
                end else begin
                    accepting = 1'b0;
                    if (model_drop < 65535) model_drop++;
                end
            end
            @(negedge clk);
        end
        pktin_valid = 1'b0;
        pktin_data  = '0;
    endtask

    task automatic check_ingress(input string name);
        checks++;
        if (drop_cnt !== 16'(model_drop) || pkt_alf !== exp_alf()) begin
            errors++;
            $display("FAIL %s: drop_cnt=%0d pkt_alf=%b, expected drop_cnt=%0d pkt_alf=%b",
                     name, drop_cnt, pkt_alf, model_drop, exp_alf());
        end
    endtask

    // A DDR-side responder with optional random stalls; every AW/W/B event is
    // compared against addresses and data derived from the packet model.
    task automatic run_frame(input bit bsel, input int bad_idx, input bit stall);
        int aw_cnt, w_idx, b_cnt, cyc;
        bit pend_b, exp_err, got_done;
        logic [IN_W-1:0]   cur;
        logic [31:0]       exp_addr;
        logic [AXI_DW-1:0] exp_slice;
        aw_cnt = 0; w_idx = 0; b_cnt = 0; cyc = 0;
        pend_b = 0; exp_err = 0; got_done = 0; cur = '0;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready_idle: got %b, expected 1", start_ready);
        end
        start_valid = 1'b1;
        start_buf   = bsel;
        @(negedge clk);
        start_valid = 1'b0;
        checks++;
        if (axi.awvalid !== (model_q.size() > 0) || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_to_aw: awvalid=%b start_ready=%b, expected awvalid=%b start_ready=0",
                     axi.awvalid, start_ready, model_q.size() > 0);
        end
        while (!got_done && cyc < 2000) begin
            axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.bvalid  = 1'b0;
            axi.bresp   = 2'b00;
            if (axi.awvalid) begin
                exp_addr = (bsel ? BUF1 : BUF0) + 32'(aw_cnt * BEAT_BYTES);
                checks++;
                if ({axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awprot,
                     axi.awlock, axi.awqos, axi.awid} !==
                    {exp_addr, 8'd7, 3'd3, 2'b01, 4'b0011, 3'b000, 1'b0, 4'h0, 4'h0}
                    || aw_cnt != b_cnt || aw_cnt >= FRAME_BEATS) begin
                    errors++;
                    $display("FAIL aw_burst%0d: awaddr=%h awlen=%0d awsize=%0d awburst=%b awcache=%b, expected awaddr=%h awlen=7 awsize=3 awburst=01 awcache=0011 (outstanding b=%0d)",
                             aw_cnt, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awcache,
                             exp_addr, aw_cnt - b_cnt);
                end
                if (axi.awready) begin
                    cur = (model_q.size() > 0) ? model_q[0] : '0;
                    aw_cnt++;
                    w_idx = 0;
                end
            end
            if (axi.wvalid) begin
                exp_slice = cur[w_idx*AXI_DW +: AXI_DW];
                checks++;
                if (axi.wdata !== exp_slice || axi.wlast !== (w_idx == NSLICE - 1) ||
                    axi.wstrb !== 8'hFF || aw_cnt != b_cnt + 1) begin
                    errors++;
                    $display("FAIL w_burst%0d_slice%0d: wdata=%h wlast=%b wstrb=%h, expected wdata=%h wlast=%b wstrb=ff",
                             aw_cnt - 1, w_idx, axi.wdata, axi.wlast, axi.wstrb,
                             exp_slice, w_idx == NSLICE - 1);
                end
                if (axi.wready) begin
                    if (w_idx == NSLICE - 1) begin
                        if (model_q.size() > 0) void'(model_q.pop_front());
                        pend_b = 1;
                        w_idx  = 0;
                    end else begin
                        w_idx++;
                    end
                end
            end
            if (pend_b && axi.bready && (!stall || $urandom_range(0, 1) == 1)) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (b_cnt == bad_idx) ? 2'b10 : 2'b00;
                exp_err    = exp_err | (b_cnt == bad_idx);
                b_cnt++;
                pend_b = 0;
            end
            if (done_valid) begin
                checks++;
                if (done_buf !== bsel || done_err !== exp_err || b_cnt != FRAME_BEATS) begin
                    errors++;
                    $display("FAIL done: done_buf=%b done_err=%b after %0d bursts, expected done_buf=%b done_err=%b after %0d",
                             done_buf, done_err, b_cnt, bsel, exp_err, FRAME_BEATS);
                end
                done_ready = 1'b1;
                got_done   = 1;
            end
            @(negedge clk);
            cyc++;
        end
        done_ready  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL frame_timeout: no done after %0d cycles, %0d of %0d bursts acknowledged",
                     cyc, b_cnt, FRAME_BEATS);
        end
        checks++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_release: done_valid=%b start_ready=%b, expected 0 and 1",
                     done_valid, start_ready);
        end
        check_ingress("post_frame_ingress");
    endtask

    task automatic test_reset();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        aresetn     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready, done_valid, done_buf, done_err,
             start_ready, pkt_alf, drop_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_values: awvalid=%b wvalid=%b wlast=%b bready=%b done=%b%b%b start_ready=%b alf=%b drop=%0d, expected all 0",
                     axi.awvalid, axi.wvalid, axi.wlast, axi.bready, done_valid, done_buf,
                     done_err, start_ready, pkt_alf, drop_cnt);
        end
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || axi.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_clock: start_ready=%b awvalid=%b, expected 1 and 0",
                     start_ready, axi.awvalid);
        end
    endtask

    task automatic test_mismatch();
        send_packet(1, 3);
        check_ingress("dst_mismatch");
        send_packet(2, 3);
        check_ingress("src_mismatch");
        send_packet(0, 0);
        check_ingress("single_header_only");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_axi: awvalid=%b wvalid=%b, expected 0", axi.awvalid, axi.wvalid);
            end
        end
    endtask

    task automatic test_frame();
        send_packet(0, 4);
        check_ingress("frame_fill");
        run_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_overflow_stall();
        send_packet(0, 8);
        check_ingress("overflow_first");
        send_packet(0, 2);
        check_ingress("overflow_second");
        send_packet(1, 3);
        check_ingress("overflow_mismatch");
        run_frame(1'b0, -1, 1'b1);
    endtask

    task automatic test_bresp_err();
        send_packet(0, 4);
        run_frame(1'b0, 1, 1'b1);
        send_packet(0, 4);
        run_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_packet(0, 4);
        start_valid = 1'b1;
        start_buf   = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = 1'b0;
        cyc = 0;
        while (!axi.wvalid && cyc < 50) begin
            @(negedge clk);
            axi.awready = 1'b0;
            cyc++;
        end
        checks++;
        if (axi.wvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach_w: wvalid=%b, expected 1", axi.wvalid);
        end
        axi.wready = 1'b1;
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready, done_valid, start_ready,
             pkt_alf, drop_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: awvalid=%b wvalid=%b wlast=%b bready=%b done_valid=%b start_ready=%b alf=%b drop=%0d, expected all 0",
                     axi.awvalid, axi.wvalid, axi.wlast, axi.bready, done_valid, start_ready,
                     pkt_alf, drop_cnt);
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        model_q.delete();
        model_drop = 0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || pkt_alf !== 1'b0 || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover: start_ready=%b pkt_alf=%b done_valid=%b, expected 1 0 0",
                     start_ready, pkt_alf, done_valid);
        end
        send_packet(0, 4);
        run_frame(1'b0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_mismatch();
        test_frame();
        test_overflow_stall();
        test_bresp_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
